// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the six-digit multiplexed clock display.
// All glyphs are active-low, with seg[0]=a through seg[6]=g.
package seven_seg_scanner_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [5:0] AN_OFF    = 6'h3F;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes above 9 are shown as a dash so corrupt digits are visible on the display.
module bcd_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans a coherent HH:MM:SS snapshot onto a six-digit common-anode display,
// with ghost blanking, hour leading-zero suppression and a blinking separator.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50_000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] hour_tens,
    input  logic       blank_lz,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int SLOT_W  = $clog2(DIGIT_CYCLES);
    localparam int BLINK_W = $clog2(BLINK_CYCLES);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LIT   = SLOT_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam digit_idx_t         DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    digit_idx_t         digit_idx;
    logic               blink_phase;
    bcd_t               snap [NUM_DIGITS];

    logic       frame_end;
    logic       lit;
    bcd_t       cur_bcd;
    logic [6:0] glyph;
    logic [6:0] seg_next;
    logic [5:0] an_next;
    logic       dp_next;

    assign frame_end = (slot_cnt == SLOT_LAST) && (digit_idx == DIGIT_LAST);

    // Inputs are captured only at the very end of the hour_tens slot, so every frame shows one time value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (frame_end) begin
                snap[0] <= sec_ones;
                snap[1] <= sec_tens;
                snap[2] <= min_ones;
                snap[3] <= min_tens;
                snap[4] <= hour_ones;
                snap[5] <= hour_tens;
            end
        end
    end

    always_comb begin
        cur_bcd = snap[0];
        case (digit_idx)
            3'd1:    cur_bcd = snap[1];
            3'd2:    cur_bcd = snap[2];
            3'd3:    cur_bcd = snap[3];
            3'd4:    cur_bcd = snap[4];
            3'd5:    cur_bcd = snap[5];
            default: cur_bcd = snap[0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_bcd),
        .seg (glyph)
    );

    // The first BLANK_CYCLES of each slot keep every anode off to hide the previous digit's ghost.
    always_comb begin
        lit      = (slot_cnt >= SLOT_LIT);
        an_next  = lit ? ~(6'b000001 << digit_idx) : AN_OFF;
        seg_next = glyph;
        if (blank_lz && (digit_idx == DIGIT_LAST) && (snap[NUM_DIGITS-1] == 4'd0))
            seg_next = SEG_BLANK;
        dp_next  = ~(colon_en && blink_phase && lit && ((digit_idx == 3'd2) || (digit_idx == 3'd4)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a time-indexed reference model,
// plus directed checks of reset, scan timing, glyphs and leading-zero blanking.
module tb_seven_seg_scanner;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BL = 64;
    localparam int ND = 6;
    localparam int FRAME = DC * ND;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       blank_lz, colon_en;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_tick;

    int total = 0;
    int bad = 0;

    seven_seg_scanner #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .hour_ones  (hour_ones),
        .hour_tens  (hour_tens),
        .blank_lz   (blank_lz),
        .colon_en   (colon_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ht, input logic [3:0] ho, input logic [3:0] mt,
                                 input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so,
                                 input logic blz, input logic col);
        hour_tens = ht; hour_ones = ho; min_tens = mt; min_ones = mo;
        sec_tens = st; sec_ones = so; blank_lz = blz; colon_en = col;
    endtask

    // Reference model: n counts clock edges since reset release; everything follows from n.
    logic [6:0] glyphTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] snapModel [ND];
    int         n;
    int         slotM, idxM;
    bit         litM;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expDp, expTick;

    function automatic logic [6:0] glyphOf(input logic [3:0] v);
        return (v > 4'd9) ? 7'h3F : glyphTab[v];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0;
            for (int i = 0; i < ND; i++) snapModel[i] = 4'd0;
            expAn = 6'h3F; expSeg = 7'h7F; expDp = 1'b1; expTick = 1'b0;
        end else begin
            slotM  = n % DC;
            idxM   = (n / DC) % ND;
            litM   = (slotM >= BC);
            expAn  = litM ? ~(6'b000001 << idxM) : 6'h3F;
            expSeg = (blank_lz && idxM == 5 && snapModel[5] == 4'd0) ? 7'h7F : glyphOf(snapModel[idxM]);
            expDp  = !(colon_en && ((n / BL) % 2 == 1) && (idxM == 2 || idxM == 4) && litM);
            expTick = (n % FRAME) == FRAME - 1;
            if (expTick) begin
                snapModel[0] = sec_ones;  snapModel[1] = sec_tens;
                snapModel[2] = min_ones;  snapModel[3] = min_tens;
                snapModel[4] = hour_ones; snapModel[5] = hour_tens;
            end
            n++;
        end
    end

    // Every settled cycle out of reset is compared against the model.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("an", {26'd0, an}, {26'd0, expAn});
            checkOutput("dp", {31'd0, dp}, {31'd0, expDp});
            checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, expTick});
            if (expAn != 6'h3F) checkOutput("seg", {25'd0, seg}, {25'd0, expSeg});
        end
    end

    task automatic waitTick();
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick) return;
        end
        checkOutput("tick_timeout", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic checkDigit(input string tag, input int idx, input logic [6:0] wantSeg);
        logic [5:0] wantAn;
        wantAn = ~(6'b000001 << idx);
        waitTick();
        waitTick();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (an == wantAn) break;
        end
        checkOutput({tag, "_an"}, {26'd0, an}, {26'd0, wantAn});
        checkOutput({tag, "_seg"}, {25'd0, seg}, {25'd0, wantSeg});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_an"}, {26'd0, an}, 32'h3F);
        checkOutput({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        checkOutput({tag, "_dp"}, {31'd0, dp}, 32'd1);
        checkOutput({tag, "_tick"}, {31'd0, frame_tick}, 32'd0);
    endtask

    function automatic logic [3:0] rndDigit();
        return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endfunction

    initial begin
        int firstAn, dig0, dig5, period;
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset_hold");

        reset = 1'b1;
        firstAn = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (an == 6'h3E) begin firstAn = i; break; end
        end
        checkOutput("first_an_delay", firstAn, 3);

        waitTick();
        dig0 = 0; dig5 = 0; period = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (an == 6'h3E && seg == 7'h02) dig0++;
            if (an == 6'h1F && seg == 7'h79) dig5++;
            if (frame_tick) begin period = i; break; end
        end
        checkOutput("digit0_lit_cycles", dig0, 6);
        checkOutput("digit5_lit_cycles", dig5, 6);
        checkOutput("tick_period", period, FRAME);

        repeat (20) @(negedge clk);
        applyStimulus(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);
        checkDigit("new_time_d0", 0, 7'h10);
        applyStimulus(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 1'b1, 1'b0);
        checkDigit("lz_blank", 5, 7'h7F);
        applyStimulus(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);
        checkDigit("lz_shown", 5, 7'h40);
        applyStimulus(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'hB, 1'b0, 1'b1);
        checkDigit("dash", 0, 7'h3F);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0)
                applyStimulus(rndDigit(), rndDigit(), rndDigit(), rndDigit(), rndDigit(),
                              rndDigit(), 1'($urandom_range(0, 1)), colon_en);
            if ($urandom_range(0, 3) == 0 && $urandom_range(0, 99) == 0) colon_en = ~colon_en;
            if ($urandom_range(0, 7) == 0) hour_tens = 4'd0;
            if (i == 1500 + int'($urandom_range(0, 7))) begin
                @(posedge clk);
                #2 reset = 1'b0;
                #1 checkResetValues("mid_reset");
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
